// File: rtl/interleaver_pkg.sv
// Shared constants and types for the 12-branch convolutional interleaver link,
// used by both the transmit-side distributor and the receive-side commutator.
package interleaver_pkg;

    localparam int N_BRANCH = 12;
    localparam int SEL_W    = 4;
    localparam int DATA_W   = 8;

    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

    typedef enum logic {
        ALIGN,
        RUN
    } state_t;

endpackage

// File: rtl/commutator_out_reg.sv
// Registered valid/ready output stage of the de-interleaver commutator.
// Holds data/last stable while the downstream stalls; reset discards the held byte.
module commutator_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last
);

    logic [DATA_W-1:0] data_reg;
    logic              valid_reg;
    logic              last_reg;

    // The caller only asserts load when the register is empty or being drained,
    // so a load never overwrites an unaccepted byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
        end else if (load) begin
            data_reg  <= load_data;
            valid_reg <= 1'b1;
            last_reg  <= load_last;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_data  = data_reg;
    assign out_valid = valid_reg;
    assign out_last  = last_reg;

endmodule

// File: rtl/deint_commutator_12to1.sv
// 12-to-1 output commutator: merges the de-interleaver branch lanes round-robin.
// Optional first-byte-after-sync check enabled by macro DEINT_SYNC_CHECK_EN.
module deint_commutator_12to1
    import interleaver_pkg::*;
#(
    parameter int DATA_W   = interleaver_pkg::DATA_W,
    parameter int N_BRANCH = interleaver_pkg::N_BRANCH,
    parameter int SEL_W    = interleaver_pkg::SEL_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sync_in,
    input  logic [N_BRANCH*DATA_W-1:0] in_data,
    input  logic [N_BRANCH-1:0]        in_valid,
    output logic [N_BRANCH-1:0]        in_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       sync_err
);

    state_t             state_reg;
    logic [SEL_W-1:0]   sel_reg;

    logic               space;
    logic               fetch_ok;
    logic               fire;
    logic               sel_last;
    logic [DATA_W-1:0]  lane_data;
    logic               lane_valid;

    assign space    = !out_valid || out_ready;
    // Gated by rst so that no lane is popped in a reset cycle.
    assign fetch_ok = !rst && (state_reg == RUN) && !sync_in && space;
    assign sel_last = (sel_reg == SEL_W'(N_BRANCH - 1));

    generate
        for (genvar gi = 0; gi < N_BRANCH; gi++) begin : g_ready
            assign in_ready[gi] = fetch_ok && (sel_reg == SEL_W'(gi));
        end
    endgenerate

    always_comb begin
        lane_data  = '0;
        lane_valid = 1'b0;
        for (int i = 0; i < N_BRANCH; i++) begin
            if (sel_reg == SEL_W'(i)) begin
                lane_data  = in_data[i*DATA_W +: DATA_W];
                lane_valid = in_valid[i];
            end
        end
    end

    assign fire = fetch_ok && lane_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ALIGN;
            sel_reg   <= '0;
        end else if (sync_in) begin
            state_reg <= RUN;
            sel_reg   <= '0;
        end else if (fire) begin
            sel_reg <= sel_last ? '0 : sel_reg + 1'b1;
        end
    end

    commutator_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (fire),
        .load_data (lane_data),
        .load_last (sel_last),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

`ifdef DEINT_SYNC_CHECK_EN
    logic chk_pending_reg;
    logic sync_err_reg;

    // Registered so the pulse lines up with the checked byte on out_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_pending_reg <= 1'b0;
            sync_err_reg    <= 1'b0;
        end else begin
            sync_err_reg <= 1'b0;
            if (sync_in) begin
                chk_pending_reg <= 1'b1;
            end else if (fire && chk_pending_reg) begin
                chk_pending_reg <= 1'b0;
                sync_err_reg    <= (lane_data != DATA_W'(TS_SYNC_BYTE));
            end
        end
    end

    assign sync_err = sync_err_reg;
`else
    assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_deint_commutator_12to1.sv
// Scenario bench for deint_commutator_12to1: expected bytes are queued as stimulus
// is driven and matched against bytes accepted on the output handshake.
module tb_deint_commutator_12to1;

    logic        clk = 1'b0;
    logic        rst;
    logic        sync_in;
    logic [95:0] in_data;
    logic [11:0] in_valid;
    logic [11:0] in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        sync_err;

    int total = 0;
    int bad   = 0;
    int msel  = 0;
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];

    always #5 clk = ~clk;

    deint_commutator_12to1 dut (
        .clk       (clk),
        .rst       (rst),
        .sync_in   (sync_in),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .sync_err  (sync_err)
    );

    // Record a handshake at the negedge, then advance to just after the next posedge.
    task automatic cyc();
        @(negedge clk);
        if (out_valid === 1'b1 && out_ready === 1'b1)
            obs_q.push_back({out_last, out_data});
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [7:0] base);
        for (int i = 0; i < 12; i++)
            in_data[i*8 +: 8] = base + 8'(i);
    endtask

    task automatic test_reset();
        rst = 1'b1; sync_in = 1'b0; out_ready = 1'b1; in_valid = 12'hFFF;
        set_lanes(8'h10);
        cyc(); cyc();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 12'h000 || out_data !== 8'h00 ||
            out_last !== 1'b0 || sync_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got valid=%b ready=%h data=%h last=%b err=%b, want all zero",
                     out_valid, in_ready, out_data, out_last, sync_err);
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            total++;
            if (in_ready !== 12'h000 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL align_idle[%0d]: got ready=%h valid=%b, want ready=000 valid=0",
                         k, in_ready, out_valid);
            end
        end
        $display("reset: checked");
    endtask

    task automatic test_rotation();
        set_lanes(8'h10); in_valid = 12'hFFF; out_ready = 1'b1;
        sync_in = 1'b1;
        #1;
        total++;
        if (in_ready !== 12'h000) begin
            bad++;
            $display("FAIL rot_sync_ready: got %h want 000", in_ready);
        end
        cyc();
        sync_in = 1'b0; msel = 0;
        for (int k = 0; k < 14; k++) begin
            #1;
            total++;
            if (in_ready !== (12'd1 << msel)) begin
                bad++;
                $display("FAIL rot_ready[%0d]: got %h want %h", k, in_ready, 12'd1 << msel);
            end
            exp_q.push_back({msel == 11, 8'h10 + 8'(msel)});
            msel = (msel + 1) % 12;
            cyc();
        end
        in_valid = 12'h000;
        cyc();
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rot_count: got %0d bytes want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [8:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL rot_byte: got last=%b data=%h want last=%b data=%h", o[8], o[7:0], e[8], e[7:0]);
            end else
                $display("txn rotation: data=%h last=%b", o[7:0], o[8]);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_stall_backpressure();
        in_valid = 12'hFFF; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (in_ready !== (12'd1 << msel)) begin
                bad++;
                $display("FAIL stall_pre_ready[%0d]: got %h want %h", k, in_ready, 12'd1 << msel);
            end
            exp_q.push_back({msel == 11, 8'h10 + 8'(msel)});
            msel = (msel + 1) % 12;
            cyc();
        end
        in_valid[5] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (in_ready !== 12'h020) begin
                bad++;
                $display("FAIL stall_ready[%0d]: got %h want 020", k, in_ready);
            end
            cyc();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL stall_valid[%0d]: got %b want 0", k, out_valid);
            end
        end
        in_valid[5] = 1'b1;
        #1;
        exp_q.push_back({1'b0, 8'h15});
        msel = 6;
        cyc();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if (in_ready !== 12'h000 || out_valid !== 1'b1 || out_data !== 8'h15 || out_last !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got ready=%h valid=%b data=%h last=%b want 000/1/15/0",
                         k, in_ready, out_valid, out_data, out_last);
            end
            cyc();
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 12'h040) begin
            bad++;
            $display("FAIL bp_release_ready: got %h want 040", in_ready);
        end
        exp_q.push_back({1'b0, 8'h16});
        msel = 7;
        cyc();
        in_valid = 12'h000;
        cyc();
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL stall_count: got %0d bytes want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [8:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL stall_byte: got last=%b data=%h want last=%b data=%h", o[8], o[7:0], e[8], e[7:0]);
            end else
                $display("txn stall: data=%h last=%b", o[7:0], o[8]);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_realign();
        in_valid = 12'hFFF; out_ready = 1'b1; sync_in = 1'b1;
        #1;
        total++;
        if (in_ready !== 12'h000) begin
            bad++;
            $display("FAIL realign_sync_ready: got %h want 000 (sel was %0d)", in_ready, msel);
        end
        cyc();
        sync_in = 1'b0; msel = 0;
        #1;
        total++;
        if (in_ready !== 12'h001) begin
            bad++;
            $display("FAIL realign_ready: got %h want 001", in_ready);
        end
        exp_q.push_back({1'b0, 8'h10});
        msel = 1;
        cyc();
        in_valid = 12'h000;
        cyc();
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL realign_count: got %0d bytes want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [8:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL realign_byte: got last=%b data=%h want last=%b data=%h", o[8], o[7:0], e[8], e[7:0]);
            end else
                $display("txn realign: data=%h last=%b", o[7:0], o[8]);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_sync_check();
        logic exp_err;
`ifdef DEINT_SYNC_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        out_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            logic [7:0] b;
            b = (pass == 0) ? 8'h47 : 8'h48;
            set_lanes(b);
            in_valid = 12'h001; sync_in = 1'b1;
            cyc();
            sync_in = 1'b0;
            exp_q.push_back({1'b0, b});
            cyc();
            total++;
            if (out_data !== b || out_valid !== 1'b1 || sync_err !== (pass == 0 ? 1'b0 : exp_err)) begin
                bad++;
                $display("FAIL sync_chk[%0d]: got data=%h valid=%b err=%b want data=%h valid=1 err=%b",
                         pass, out_data, out_valid, sync_err, b, (pass == 0 ? 1'b0 : exp_err));
            end
            in_valid = 12'h000;
            cyc();
            total++;
            if (sync_err !== 1'b0) begin
                bad++;
                $display("FAIL sync_chk_after[%0d]: got err=%b want 0", pass, sync_err);
            end
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL sync_count: got %0d bytes want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [8:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL sync_byte: got last=%b data=%h want last=%b data=%h", o[8], o[7:0], e[8], e[7:0]);
            end else
                $display("txn sync_check: data=%h last=%b", o[7:0], o[8]);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_midstream();
        set_lanes(8'h20); in_valid = 12'hFFF; out_ready = 1'b1; sync_in = 1'b1;
        cyc();
        sync_in = 1'b0;
        for (int k = 0; k < 9; k++) begin
            // The byte from lane 8 is still held when reset hits, so it is never delivered.
            if (k < 8) exp_q.push_back({1'b0, 8'h20 + 8'(k)});
            cyc();
        end
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h28) begin
            bad++;
            $display("FAIL mid_pre: got valid=%b data=%h want 1/28", out_valid, out_data);
        end
        rst = 1'b1; out_ready = 1'b0;
        #1;
        total++;
        if (in_ready !== 12'h000) begin
            bad++;
            $display("FAIL mid_rst_ready: got %h want 000", in_ready);
        end
        cyc();
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst_out: got valid=%b data=%h last=%b want 0/00/0", out_valid, out_data, out_last);
        end
        rst = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++;
            if (in_ready !== 12'h000) begin
                bad++;
                $display("FAIL mid_align[%0d]: got ready=%h want 000", k, in_ready);
            end
            cyc();
        end
        sync_in = 1'b1;
        cyc();
        sync_in = 1'b0;
        #1;
        total++;
        if (in_ready !== 12'h001) begin
            bad++;
            $display("FAIL mid_sel0: got ready=%h want 001", in_ready);
        end
        exp_q.push_back({1'b0, 8'h20});
        cyc();
        in_valid = 12'h000;
        cyc();
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL mid_count: got %0d bytes want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [8:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL mid_byte: got last=%b data=%h want last=%b data=%h", o[8], o[7:0], e[8], e[7:0]);
            end else
                $display("txn midstream: data=%h last=%b", o[7:0], o[8]);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        rst = 1'b1; sync_in = 1'b0; in_data = '0; in_valid = '0; out_ready = 1'b0;
        test_reset();
        test_rotation();
        test_stall_backpressure();
        test_realign();
        test_sync_check();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
